async_fifo_rd_streamer: RTL and testbench
=========================================

ASYNC_FIFO_RD_STREAMER -- requirements
Module: async_fifo_rd_streamer

Interface
REQ-001 SHALL have parameter FIFO_DATA_WIDTH, default 8: width of the FIFO read data and of the stream data.
REQ-002 SHALL have parameter LEN_WIDTH, default 16: width of the burst length and the count outputs.
REQ-003 SHALL have ports, clock and reset first:
- rclk  input  1  read-domain clock; all state changes on its rising edge.
- rrst_n  input  1  synchronous, active-low reset.
- rempty  input  1  FIFO read-side empty flag.
- rdata  input  FIFO_DATA_WIDTH  FIFO head word, valid whenever rempty=0.
- rinc  output  1  FIFO pop request; the FIFO advances on the rclk edge where rinc=1.
- start  input  1  single-cycle burst request, sampled only in IDLE.
- burst_len  input  LEN_WIDTH  number of words to pop, sampled with start.
- abort  input  1  stops further pops; level-sampled in RUN.
- m_valid  output  1  stream word valid.
- m_data  output  FIFO_DATA_WIDTH  stream word.
- m_ready  input  1  downstream accept.
- busy  output  1  high in every state except IDLE.
- done  output  1  single-cycle burst-complete pulse.
- aborted  output  1  qualifies done; held until the next start.
- pop_count  output  LEN_WIDTH  words popped in the current or last burst.

Function
REQ-004 SHALL implement the states IDLE, RUN, FLUSH and DONE.
REQ-005 IDLE -> RUN on start=1: SHALL load remaining=burst_len, clear pop_count and clear aborted.
REQ-006 IDLE with start=1 and burst_len=0 SHALL go directly to DONE, with no pop.
REQ-007 SHALL drive rinc combinationally: rinc = (state==RUN) & ~rempty & ~abort & (remaining!=0) & (skid occupancy<2, or a word leaves the skid buffer this cycle).
REQ-008 rinc SHALL never be 1 while rempty=1: no underflow pops.
REQ-009 On each edge with rinc=1, SHALL:
- write rdata into a 2-entry skid buffer;
- decrement remaining;
- increment pop_count, wrapping modulo 2^LEN_WIDTH.
REQ-010 m_valid SHALL equal skid occupancy != 0, and m_data SHALL be the oldest entry.
REQ-011 A word SHALL leave the skid buffer on an edge with m_valid & m_ready.
REQ-012 Push and pop of the skid buffer on the same edge SHALL keep the occupancy unchanged and preserve order.
REQ-013 Latency: a word popped at edge N SHALL appear on m_data after edge N when the buffer was empty, for 1 cycle of latency.
REQ-014 Throughput: SHALL sustain 1 word per rclk when rempty=0 and m_ready=1.
REQ-015 Under m_ready=0, SHALL stop popping once 2 words are buffered.
REQ-016 m_data SHALL be held stable while m_valid=1 and m_ready=0.
REQ-017 RUN -> FLUSH when remaining reaches 0 after a pop.
REQ-018 RUN -> FLUSH when abort=1; aborted SHALL be set to 1.
REQ-019 FLUSH -> DONE when the skid buffer is empty; words already buffered SHALL always be delivered, including after an abort.
REQ-020 DONE SHALL assert done=1 for exactly one cycle and then return to IDLE.
REQ-021 start SHALL be ignored outside IDLE.
REQ-022 abort SHALL be ignored outside RUN.
REQ-023 busy SHALL be 0 only in IDLE.

Reset
REQ-024 On an rclk edge with rrst_n=0, SHALL set:
- state=IDLE, remaining=0, pop_count=0;
- skid buffer empty, m_valid=0, m_data=0;
- done=0, aborted=0, busy=0.
REQ-025 rinc SHALL be 0 during reset and in the first cycle after rrst_n rises.
REQ-026 Reset in RUN or FLUSH SHALL discard buffered words without a done pulse.

Verification
REQ-027 Basic burst: 4 words A1..A4 pre-loaded, start with burst_len=4, m_ready=1 -> rinc high 4 consecutive cycles, m_data A1..A4 on consecutive cycles, pop_count=4, one done pulse, aborted=0.
REQ-028 Backpressure: burst_len=6, m_ready=0 for 5 cycles -> exactly 2 pops, then rinc=0 with m_data held at word 1; after m_ready=1, all 6 words are delivered in order.
REQ-029 Empty stall: burst_len=3 with the FIFO empty, then one word written every 4 wclk -> no rinc while rempty=1, 3 pops total, done only after the third word is accepted.
REQ-030 Abort: burst_len=10 with abort raised after 3 pops -> no further rinc, 3 words delivered, done=1 with aborted=1, pop_count=3.
REQ-031 Zero length and ignored start: burst_len=0 -> done on the cycle after start with no rinc; a start pulsed during RUN has no effect.
REQ-032 Reset mid-burst: rrst_n=0 in RUN with 2 words buffered -> m_valid=0, busy=0, pop_count=0 on the next edge, with no done pulse.

Source files
------------

// File: rtl/async_fifo_rd_streamer.sv
// Read-side burst streamer: pops a counted burst from an async FIFO
// into a 2-entry skid buffer feeding a valid/ready stream.
module async_fifo_rd_streamer #(
  parameter int FIFO_DATA_WIDTH = 8,
  parameter int LEN_WIDTH       = 16
) (
  input  logic                       rclk,
  input  logic                       rrst_n,
  input  logic                       rempty,
  input  logic [FIFO_DATA_WIDTH-1:0] rdata,
  output logic                       rinc,
  input  logic                       start,
  input  logic [LEN_WIDTH-1:0]       burst_len,
  input  logic                       abort,
  output logic                       m_valid,
  output logic [FIFO_DATA_WIDTH-1:0] m_data,
  input  logic                       m_ready,
  output logic                       busy,
  output logic                       done,
  output logic                       aborted,
  output logic [LEN_WIDTH-1:0]       pop_count
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FLUSH,
    DONE
  } state_t;

  state_t                     state;
  state_t                     state_nx;
  logic [LEN_WIDTH-1:0]       remaining;
  logic [FIFO_DATA_WIDTH-1:0] e0;
  logic [FIFO_DATA_WIDTH-1:0] e1;
  logic [1:0]                 occ;
  logic                       take;
  logic                       room;
  logic                       last_pop;

  assign m_valid  = (occ != 2'd0);
  assign m_data   = e0;
  assign take     = m_valid & m_ready;
  assign room     = (occ != 2'd2) | take;
  assign busy     = (state != IDLE);
  assign done     = (state == DONE);
  assign last_pop = rinc & (remaining == LEN_WIDTH'(1));

  // rrst_n gating keeps rinc low while reset is held
  assign rinc = rrst_n & (state == RUN) & ~rempty & ~abort
              & (remaining != '0) & room;

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: begin
        if (start)
          state_nx = (burst_len == '0) ? DONE : RUN;
      end
      RUN: begin
        if (abort || last_pop || remaining == '0)
          state_nx = FLUSH;
      end
      FLUSH: begin
        if (occ == 2'd0)
          state_nx = DONE;
      end
      DONE: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge rclk) begin
    if (!rrst_n) begin
      state     <= IDLE;
      remaining <= '0;
      pop_count <= '0;
      aborted   <= 1'b0;
    end else begin
      state <= state_nx;
      if (state == IDLE && start) begin
        remaining <= burst_len;
        pop_count <= '0;
        aborted   <= 1'b0;
      end
      if (state == RUN && abort)
        aborted <= 1'b1;
      if (rinc) begin
        remaining <= remaining - LEN_WIDTH'(1);
        pop_count <= pop_count + LEN_WIDTH'(1);
      end
    end
  end

  // e0 is always the oldest word; e1 only holds data when occ==2
  always_ff @(posedge rclk) begin
    if (!rrst_n) begin
      e0  <= '0;
      e1  <= '0;
      occ <= 2'd0;
    end else begin
      unique case ({rinc, take})
        2'b10: begin
          if (occ == 2'd0) e0 <= rdata;
          else             e1 <= rdata;
          occ <= occ + 2'd1;
        end
        2'b01: begin
          e0  <= e1;
          occ <= occ - 2'd1;
        end
        2'b11: begin
          if (occ == 2'd1) begin
            e0 <= rdata;
          end else begin
            e0 <= e1;
            e1 <= rdata;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_async_fifo_rd_streamer.sv
// Randomized bench for async_fifo_rd_streamer with a queue FIFO model
// and an in-order expected-stream reference.
module tb_async_fifo_rd_streamer;

  logic        rclk = 1'b0;
  logic        rrst_n = 1'b0;
  logic        rempty = 1'b1;
  logic [7:0]  rdata = '0;
  logic        rinc;
  logic        start = 1'b0;
  logic [15:0] burst_len = '0;
  logic        abort = 1'b0;
  logic        m_valid;
  logic [7:0]  m_data;
  logic        m_ready = 1'b1;
  logic        busy;
  logic        done;
  logic        aborted;
  logic [15:0] pop_count;

  int tests = 0;
  int fails = 0;

  logic [7:0] fq[$];
  logic [7:0] got[$];
  logic [7:0] exp_q[$];
  int npops, ndone, cyc;
  int underflow_cnt, unstable_cnt;
  int first_pop_cyc, first_acc_cyc, last_acc_cyc, done_cyc;
  int cur_run, max_run;
  bit last_rinc, last_done, aborted_at_done;
  bit prev_stall;
  logic [7:0] prev_data;

  always #5 rclk = ~rclk;

  async_fifo_rd_streamer #(
    .FIFO_DATA_WIDTH(8),
    .LEN_WIDTH(16)
  ) dut (
    .rclk(rclk),
    .rrst_n(rrst_n),
    .rempty(rempty),
    .rdata(rdata),
    .rinc(rinc),
    .start(start),
    .burst_len(burst_len),
    .abort(abort),
    .m_valid(m_valid),
    .m_data(m_data),
    .m_ready(m_ready),
    .busy(busy),
    .done(done),
    .aborted(aborted),
    .pop_count(pop_count)
  );

  task automatic refresh();
    rempty = (fq.size() == 0);
    rdata  = rempty ? 8'h00 : fq[0];
  endtask

  task automatic push_word(input logic [7:0] w);
    fq.push_back(w);
    exp_q.push_back(w);
    refresh();
  endtask

  task automatic clear_stats();
    fq.delete();
    got.delete();
    exp_q.delete();
    npops = 0; ndone = 0; cyc = 0;
    underflow_cnt = 0; unstable_cnt = 0;
    first_pop_cyc = -1; first_acc_cyc = -1;
    last_acc_cyc = -1; done_cyc = -1;
    cur_run = 0; max_run = 0;
    aborted_at_done = 0;
    prev_stall = 0;
    refresh();
  endtask

  task automatic tick();
    bit r, a, d;
    logic [7:0] ad;
    #2;
    r  = (rinc === 1'b1);
    a  = (m_valid === 1'b1) && (m_ready === 1'b1);
    ad = m_data;
    d  = (done === 1'b1);
    if (r && rempty) underflow_cnt++;
    if (prev_stall && rrst_n &&
        (m_valid !== 1'b1 || m_data !== prev_data))
      unstable_cnt++;
    prev_stall = rrst_n && (m_valid === 1'b1) && !m_ready;
    prev_data  = m_data;
    if (d) begin
      ndone++;
      done_cyc = cyc;
      aborted_at_done = (aborted === 1'b1);
    end
    @(posedge rclk);
    #1;
    if (r && fq.size() > 0) begin
      void'(fq.pop_front());
      npops++;
      if (npops == 1) first_pop_cyc = cyc;
    end
    cur_run = r ? cur_run + 1 : 0;
    if (cur_run > max_run) max_run = cur_run;
    if (a) begin
      got.push_back(ad);
      if (got.size() == 1) first_acc_cyc = cyc;
      last_acc_cyc = cyc;
    end
    last_rinc = r;
    last_done = d;
    cyc++;
    refresh();
  endtask

  task automatic start_burst(input int len);
    start = 1'b1;
    burst_len = 16'(len);
    tick();
    start = 1'b0;
  endtask

  task automatic run_until_done(input int budget, output bit to);
    for (int i = 0; i < budget && ndone == 0; i++) tick();
    to = (ndone == 0);
    tick();
    tick();
  endtask

  function automatic bit stream_ok(input int n);
    if (got.size() != n || exp_q.size() < n) return 0;
    for (int i = 0; i < n; i++)
      if (got[i] !== exp_q[i]) return 0;
    return 1;
  endfunction

  task automatic test_reset();
    clear_stats();
    rrst_n = 1'b0;
    tick();
    tick();
    tests++;
    if (m_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      fails++;
      $display("FAIL reset_flags: valid=%b busy=%b done=%b want 000",
               m_valid, busy, done);
    end
    tests++;
    if (pop_count !== 16'd0 || m_data !== 8'd0 || aborted !== 1'b0) begin
      fails++;
      $display("FAIL reset_regs: cnt=%0d data=%0h ab=%b want 0",
               pop_count, m_data, aborted);
    end
    tests++;
    if (last_rinc !== 1'b0) begin
      fails++;
      $display("FAIL reset_rinc: got %b want 0", last_rinc);
    end
    rrst_n = 1'b1;
    push_word(8'hAA);
    tick();
    tests++;
    if (last_rinc !== 1'b0) begin
      fails++;
      $display("FAIL post_reset_rinc: got %b want 0", last_rinc);
    end
  endtask

  task automatic test_basic();
    bit to;
    clear_stats();
    m_ready = 1'b1;
    for (int i = 0; i < 4; i++) push_word(8'($urandom));
    start_burst(4);
    run_until_done(40, to);
    tests++;
    if (to || npops != 4 || max_run != 4) begin
      fails++;
      $display("FAIL basic_pops: pops=%0d run=%0d to=%0d want 4/4/0",
               npops, max_run, to);
    end
    tests++;
    if (!stream_ok(4)) begin
      fails++;
      $display("FAIL basic_stream: got %0d words want 4 in order",
               got.size());
    end
    tests++;
    if (first_acc_cyc != first_pop_cyc + 1 ||
        last_acc_cyc != first_acc_cyc + 3) begin
      fails++;
      $display("FAIL basic_timing: pop@%0d acc@%0d..%0d want +1,+3",
               first_pop_cyc, first_acc_cyc, last_acc_cyc);
    end
    tests++;
    if (pop_count !== 16'd4 || ndone != 1 || aborted !== 1'b0) begin
      fails++;
      $display("FAIL basic_end: cnt=%0d done=%0d ab=%b want 4/1/0",
               pop_count, ndone, aborted);
    end
  endtask

  task automatic test_backpressure();
    bit to;
    clear_stats();
    m_ready = 1'b0;
    for (int i = 0; i < 6; i++) push_word(8'($urandom));
    start_burst(6);
    for (int i = 0; i < 5; i++) tick();
    tests++;
    if (npops != 2 || last_rinc !== 1'b0) begin
      fails++;
      $display("FAIL bp_stall: pops=%0d rinc=%b want 2/0",
               npops, last_rinc);
    end
    tests++;
    if (m_valid !== 1'b1 || m_data !== exp_q[0]) begin
      fails++;
      $display("FAIL bp_hold: v=%b data=%0h want 1/%0h",
               m_valid, m_data, exp_q[0]);
    end
    m_ready = 1'b1;
    run_until_done(60, to);
    tests++;
    if (to || !stream_ok(6) || unstable_cnt != 0) begin
      fails++;
      $display("FAIL bp_stream: n=%0d unstable=%0d to=%0d want 6/0/0",
               got.size(), unstable_cnt, to);
    end
    tests++;
    if (pop_count !== 16'd6) begin
      fails++;
      $display("FAIL bp_count: got %0d want 6", pop_count);
    end
  endtask

  task automatic test_empty_stall();
    int pushed = 0;
    clear_stats();
    m_ready = 1'b1;
    start_burst(3);
    for (int i = 0; i < 80 && ndone == 0; i++) begin
      if (i % 4 == 3 && pushed < 3) begin
        push_word(8'($urandom));
        pushed++;
      end
      tick();
    end
    tick();
    tests++;
    if (underflow_cnt != 0 || npops != 3) begin
      fails++;
      $display("FAIL stall_pops: underflow=%0d pops=%0d want 0/3",
               underflow_cnt, npops);
    end
    tests++;
    if (!stream_ok(3) || ndone != 1 || done_cyc <= last_acc_cyc) begin
      fails++;
      $display("FAIL stall_done: n=%0d done=%0d @%0d acc@%0d",
               got.size(), ndone, done_cyc, last_acc_cyc);
    end
  endtask

  task automatic test_abort();
    bit to;
    clear_stats();
    m_ready = 1'b1;
    for (int i = 0; i < 10; i++) push_word(8'($urandom));
    start_burst(10);
    for (int i = 0; i < 20 && npops < 3; i++) tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    tests++;
    if (last_rinc !== 1'b0) begin
      fails++;
      $display("FAIL abort_rinc: got %b want 0", last_rinc);
    end
    run_until_done(40, to);
    tests++;
    if (to || npops != 3 || !stream_ok(3)) begin
      fails++;
      $display("FAIL abort_stream: pops=%0d n=%0d to=%0d want 3/3/0",
               npops, got.size(), to);
    end
    tests++;
    if (!aborted_at_done || pop_count !== 16'd3 || aborted !== 1'b1) begin
      fails++;
      $display("FAIL abort_flags: ab@done=%0d ab=%b cnt=%0d want 1/1/3",
               aborted_at_done, aborted, pop_count);
    end
  endtask

  task automatic test_zero_and_ignored();
    bit to;
    clear_stats();
    push_word(8'h11);
    start_burst(0);
    tick();
    tests++;
    if (last_done !== 1'b1 || npops != 0) begin
      fails++;
      $display("FAIL zero_len: done=%b pops=%0d want 1/0",
               last_done, npops);
    end
    tick();
    tests++;
    if (last_done !== 1'b0 || ndone != 1) begin
      fails++;
      $display("FAIL zero_pulse: done=%b n=%0d want 0/1",
               last_done, ndone);
    end
    clear_stats();
    for (int i = 0; i < 8; i++) push_word(8'($urandom));
    start_burst(5);
    tick();
    start_burst(2);
    run_until_done(40, to);
    tests++;
    if (to || npops != 5 || pop_count !== 16'd5 || ndone != 1) begin
      fails++;
      $display("FAIL ign_start: pops=%0d cnt=%0d done=%0d want 5/5/1",
               npops, pop_count, ndone);
    end
    tests++;
    if (busy !== 1'b0 || !stream_ok(5)) begin
      fails++;
      $display("FAIL ign_idle: busy=%b n=%0d want 0/5",
               busy, got.size());
    end
  endtask

  task automatic test_reset_mid();
    clear_stats();
    m_ready = 1'b0;
    for (int i = 0; i < 4; i++) push_word(8'($urandom));
    start_burst(4);
    for (int i = 0; i < 10 && npops < 2; i++) tick();
    tick();
    rrst_n = 1'b0;
    tick();
    tests++;
    if (m_valid !== 1'b0 || busy !== 1'b0 || pop_count !== 16'd0) begin
      fails++;
      $display("FAIL rst_mid: v=%b busy=%b cnt=%0d want 0/0/0",
               m_valid, busy, pop_count);
    end
    rrst_n = 1'b1;
    m_ready = 1'b1;
    for (int i = 0; i < 6; i++) tick();
    tests++;
    if (ndone != 0 || npops != 2 || got.size() != 0) begin
      fails++;
      $display("FAIL rst_nodone: done=%0d pops=%0d n=%0d want 0/2/0",
               ndone, npops, got.size());
    end
  endtask

  task automatic test_random();
    for (int b = 0; b < 6; b++) begin
      int len;
      int pushed;
      clear_stats();
      len = $urandom_range(1, 8);
      pushed = 0;
      start = 1'b1;
      burst_len = 16'(len);
      for (int i = 0; i < 400 && ndone == 0; i++) begin
        if (pushed < len + 2 && ($urandom % 2) == 1) begin
          push_word(8'($urandom));
          pushed++;
        end
        m_ready = ($urandom % 2) == 1;
        tick();
        start = 1'b0;
      end
      tick();
      tick();
      tests++;
      if (ndone != 1 || npops != len || !stream_ok(len) ||
          underflow_cnt != 0 || unstable_cnt != 0 ||
          pop_count !== 16'(len)) begin
        fails++;
        $display("FAIL rand_%0d: len=%0d pops=%0d n=%0d done=%0d uf=%0d us=%0d",
                 b, len, npops, got.size(), ndone,
                 underflow_cnt, unstable_cnt);
      end
    end
    m_ready = 1'b1;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_empty_stall();
    test_abort();
    test_zero_and_ignored();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
